// File: rtl/phase_acc_ctrl.sv
// Sequences load/accumulate strobes to a CFO phase accumulator across the symbols of one frame.
// A frame is armed by a frequency estimate and ends with a one-cycle frame_done pulse.
module phase_acc_ctrl #(
  parameter int SYM_LEN = 80,
  parameter int NSYM_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     est_valid,
  input  logic signed [15:0]       est_phase,
  input  logic        [NSYM_W-1:0] nsym,
  input  logic                     abort,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     out_ready,
  output logic                     pa_ld,
  output logic                     pa_acc,
  output logic                     pa_ce,
  output logic signed [15:0]       pa_phase_in,
  output logic                     sym_start,
  output logic                     frame_done,
  output logic                     busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] LAST_SAMP = 8'(SYM_LEN - 1);

  logic [1:0]        state;
  logic [7:0]        samp_cnt;
  logic [NSYM_W-1:0] sym_cnt;
  logic [NSYM_W-1:0] nsym_lat;
  logic              first;
  logic              xfer;
  logic              samp_wrap;
  logic              last_xfer;

  // Abort masks every handshake and strobe in the same cycle it is seen.
  always_comb begin
    xfer       = (state == RUN) && in_valid && out_ready && !abort;
    in_ready   = (state == RUN) && out_ready && !abort;
    pa_ce      = xfer;
    pa_ld      = xfer && first;
    pa_acc     = xfer && !first;
    sym_start  = xfer && (samp_cnt == 8'd0);
    frame_done = (state == DONE) && !abort;
    busy       = (state != IDLE);
    samp_wrap  = (samp_cnt == LAST_SAMP);
    last_xfer  = xfer && samp_wrap && (sym_cnt == nsym_lat - NSYM_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      samp_cnt    <= '0;
      sym_cnt     <= '0;
      nsym_lat    <= '0;
      first       <= 1'b0;
      pa_phase_in <= '0;
    end else if (abort) begin
      state    <= IDLE;
      samp_cnt <= '0;
      sym_cnt  <= '0;
      first    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (est_valid) begin
            pa_phase_in <= est_phase;
            nsym_lat    <= nsym;
            samp_cnt    <= '0;
            sym_cnt     <= '0;
            first       <= (nsym != '0);
            state       <= (nsym != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (xfer) begin
            first <= 1'b0;
            if (samp_wrap) begin
              samp_cnt <= '0;
              sym_cnt  <= sym_cnt + NSYM_W'(1);
            end else begin
              samp_cnt <= samp_cnt + 8'd1;
            end
            if (last_xfer) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_acc_ctrl.sv
// Bench for phase_acc_ctrl: a short vector table followed by frame-level sequences
// (full frame, stalled frame, abort, asynchronous reset).
module tb_phase_acc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        est_valid;
  logic [15:0] est_phase;
  logic [7:0]  nsym;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic        out_ready;
  logic        pa_ld, pa_acc, pa_ce;
  logic signed [15:0] pa_phase_in;
  logic        sym_start, frame_done, busy;

  phase_acc_ctrl #(.SYM_LEN(80), .NSYM_W(8)) dut (
    .clk(clk), .rst(rst), .est_valid(est_valid), .est_phase(est_phase),
    .nsym(nsym), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .pa_ld(pa_ld), .pa_acc(pa_acc), .pa_ce(pa_ce),
    .pa_phase_in(pa_phase_in), .sym_start(sym_start), .frame_done(frame_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ir;
    logic        ce;
    logic        ld;
    logic        acc;
    logic        ss;
    logic        fd;
    logic        bsy;
    logic [15:0] ph;
  } out_t;

  typedef struct {
    logic        ev;
    logic [15:0] ph;
    logic [7:0]  ns;
    logic        ab;
    logic        iv;
    logic        orr;
    out_t        exp_o;
  } vec_t;

  out_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  function automatic out_t mk(logic ir, logic ce, logic ld, logic acc, logic ss,
                              logic fd, logic bsy, logic [15:0] ph);
    out_t o;
    o.ir = ir; o.ce = ce; o.ld = ld; o.acc = acc; o.ss = ss;
    o.fd = fd; o.bsy = bsy; o.ph = ph;
    return o;
  endfunction

  task automatic drive(logic ev, logic [15:0] ph, logic [7:0] ns, logic ab,
                       logic iv, logic orr);
    @(negedge clk);
    est_valid = ev; est_phase = ph; nsym = ns; abort = ab;
    in_valid = iv; out_ready = orr;
  endtask

  task automatic push_exp(string nm, out_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic check_out();
    out_t  e, a;
    string nm;
    #1;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    a  = mk(in_ready, pa_ce, pa_ld, pa_acc, sym_start, frame_done, busy, pa_phase_in);
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s t=%0t actual ir/ce/ld/acc/ss/fd/busy=%b%b%b%b%b%b%b ph=%h required %b%b%b%b%b%b%b ph=%h",
                  nm, $time, a.ir, a.ce, a.ld, a.acc, a.ss, a.fd, a.bsy, a.ph,
                  e.ir, e.ce, e.ld, e.acc, e.ss, e.fd, e.bsy, e.ph);
  endtask

  task automatic check_flag(string nm, int act, int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual %0d required %0d", nm, act, req);
  endtask

  vec_t vecs[13];

  initial begin
    logic [15:0] ph;
    int          pulses;
    int          done_seen;
    int          done_cycle;
    int          last_ce_cycle;
    logic        orr;

    vecs[0]  = '{1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,16'h0000)};
    vecs[1]  = '{1'b1, 16'h0ABC, 8'd0, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,16'h0000)};
    vecs[2]  = '{1'b0, 16'h0000, 8'd0, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,0,1,1,16'h0ABC)};
    vecs[3]  = '{1'b0, 16'h0000, 8'd0, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,0,0,0,16'h0ABC)};
    vecs[4]  = '{1'b1, 16'h1111, 8'd3, 1'b1, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,16'h0ABC)};
    vecs[5]  = '{1'b0, 16'h0000, 8'd0, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,0,0,0,16'h0ABC)};
    vecs[6]  = '{1'b1, 16'h2222, 8'd1, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,0,0,0,16'h0ABC)};
    vecs[7]  = '{1'b0, 16'h0000, 8'd0, 1'b0, 1'b1, 1'b0, mk(0,0,0,0,0,0,1,16'h2222)};
    vecs[8]  = '{1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 1'b1, mk(1,0,0,0,0,0,1,16'h2222)};
    vecs[9]  = '{1'b0, 16'h0000, 8'd0, 1'b0, 1'b1, 1'b1, mk(1,1,1,0,1,0,1,16'h2222)};
    vecs[10] = '{1'b0, 16'h0000, 8'd0, 1'b0, 1'b1, 1'b1, mk(1,1,0,1,0,0,1,16'h2222)};
    vecs[11] = '{1'b0, 16'h0000, 8'd0, 1'b1, 1'b1, 1'b1, mk(0,0,0,0,0,0,1,16'h2222)};
    vecs[12] = '{1'b0, 16'h0000, 8'd0, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,0,0,0,16'h2222)};

    rst = 1'b1;
    est_valid = 0; est_phase = 0; nsym = 0; abort = 0; in_valid = 1; out_ready = 1;
    #12;
    push_exp("reset_hold", mk(0,0,0,0,0,0,0,16'h0000));
    check_out();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].ev, vecs[i].ph, vecs[i].ns, vecs[i].ab, vecs[i].iv, vecs[i].orr);
      push_exp($sformatf("vec%0d", i), vecs[i].exp_o);
      check_out();
    end

    // Full two-symbol frame, second estimate mid-frame must be ignored.
    drive(1, 16'h0FB5, 8'd2, 0, 1, 1);
    push_exp("frame_c0", mk(0,0,0,0,0,0,0,16'h2222));
    check_out();
    for (int c = 1; c <= 163; c++) begin
      logic ld, acc, ss, fd, bsy;
      drive(c == 50, (c == 50) ? 16'h1234 : 16'h0000, 8'd2, 0, 1, 1);
      ld  = (c == 1);
      acc = (c >= 2) && (c <= 160);
      ss  = (c == 1) || (c == 81);
      fd  = (c == 161);
      bsy = (c >= 1) && (c <= 161);
      push_exp($sformatf("frame_c%0d", c), mk(c <= 160, ld | acc, ld, acc, ss, fd, bsy, 16'h0FB5));
      check_out();
    end

    // Same frame with out_ready toggling every cycle.
    drive(1, 16'h0FB5, 8'd2, 0, 1, 1);
    push_exp("stall_c0", mk(0,0,0,0,0,0,0,16'h0FB5));
    check_out();
    pulses = 0; done_seen = 0; done_cycle = -1; last_ce_cycle = -1;
    for (int c = 1; c <= 330; c++) begin
      logic ce_e, run_e;
      orr = (c % 2 == 1);
      drive(0, 16'h0000, 8'd0, 0, 1, orr);
      run_e = (pulses < 160);
      ce_e  = run_e && orr;
      push_exp($sformatf("stall_c%0d", c),
               mk(run_e && orr, ce_e, ce_e && pulses == 0, ce_e && pulses != 0,
                  ce_e && (pulses % 80 == 0), (pulses == 160) && (done_seen == 0) && (c == last_ce_cycle + 1),
                  run_e || ((pulses == 160) && (c == last_ce_cycle + 1)), 16'h0FB5));
      check_out();
      if (frame_done) begin done_seen++; done_cycle = c; end
      if (pa_ce) begin pulses++; last_ce_cycle = c; end
    end
    check_flag("stall_ce_count", pulses, 160);
    check_flag("stall_done_count", done_seen, 1);
    check_flag("stall_done_after_last", done_cycle, last_ce_cycle + 1);

    // Abort at sample 37 of symbol 0.
    drive(1, 16'h0100, 8'd1, 0, 1, 1);
    push_exp("abort_c0", mk(0,0,0,0,0,0,0,16'h0FB5));
    check_out();
    for (int c = 1; c <= 37; c++) begin
      drive(0, 16'h0000, 8'd0, 0, 1, 1);
      push_exp($sformatf("abort_c%0d", c), mk(1,1,c == 1,c != 1,c == 1,0,1,16'h0100));
      check_out();
    end
    drive(1, 16'h5555, 8'd1, 1, 1, 1);
    push_exp("abort_cycle", mk(0,0,0,0,0,0,1,16'h0100));
    check_out();
    for (int c = 0; c < 3; c++) begin
      drive(0, 16'h0000, 8'd0, 0, 1, 1);
      push_exp($sformatf("abort_idle%0d", c), mk(0,0,0,0,0,0,0,16'h0100));
      check_out();
    end
    drive(1, 16'h0200, 8'd1, 0, 1, 1);
    push_exp("abort_rearm", mk(0,0,0,0,0,0,0,16'h0100));
    check_out();
    drive(0, 16'h0000, 8'd0, 0, 1, 1);
    push_exp("abort_fresh_ld", mk(1,1,1,0,1,0,1,16'h0200));
    check_out();
    for (int c = 0; c < 8; c++) begin
      drive(0, 16'h0000, 8'd0, 0, 1, 1);
      push_exp($sformatf("pre_rst%0d", c), mk(1,1,0,1,0,0,1,16'h0200));
      check_out();
    end

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    #2 rst = 1'b1;
    push_exp("async_rst", mk(0,0,0,0,0,0,0,16'h0000));
    check_out();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(0, 16'h0000, 8'd0, 0, 1, 1);
      push_exp($sformatf("post_rst%0d", c), mk(0,0,0,0,0,0,0,16'h0000));
      check_out();
    end
    drive(1, 16'h0300, 8'd1, 0, 1, 1);
    push_exp("resume_c0", mk(0,0,0,0,0,0,0,16'h0000));
    check_out();
    drive(0, 16'h0000, 8'd0, 0, 1, 1);
    push_exp("resume_ld", mk(1,1,1,0,1,0,1,16'h0300));
    check_out();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
